pc_ras: RTL and testbench

//  Parametrised program counter with a return-address stack (RAS) for call/return.

---
 rtl/pc_ras.sv | 113 +++++++++++
 tb/tb_pc_ras.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/pc_ras.sv
// Program counter with a LIFO return-address stack for call/ret, plus sticky overflow/underflow flags.
// Latency: one cycle. Every op commits at the clock edge, and pc, depth_cnt and the flags are visible the next cycle.
// Backpressure: none. One op per cycle by fixed priority (ret > call > jmp > sub > add > inc); a call when full or a ret when empty holds state and sets a flag.
module pc_ras #(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned DEPTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VEC = '0,
  localparam int unsigned CW       = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             add,
  input  logic             sub,
  input  logic             jmp,
  input  logic             call,
  input  logic             ret,
  input  logic             clr_err,
  input  logic [WIDTH-1:0] offset,
  input  logic [WIDTH-1:0] target,
  output logic [WIDTH-1:0] pc,
  output logic [CW-1:0]    depth_cnt,
  output logic             stk_empty,
  output logic             stk_full,
  output logic             ovf,
  output logic             unf
);

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [CW-1:0]    depth_q, depth_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic [WIDTH-1:0] stack_q [DEPTH];
  logic [WIDTH-1:0] top;
  logic [WIDTH-1:0] pc_plus1;
  logic             push;
  logic             empty, full;

  assign empty    = (depth_q == '0);
  assign full     = (depth_q == CW'(DEPTH));
  assign pc_plus1 = pc_q + WIDTH'(1);

  // Read the current top-of-stack entry, which sits at index depth-1.
  always_comb begin
    top = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (depth_q == CW'(i + 1)) top = stack_q[i];
    end
  end

  // Decode the winning op and form the next pc, depth and flags.
  always_comb begin
    pc_d    = pc_q;
    depth_d = depth_q;
    push    = 1'b0;
    ovf_d   = ovf_q & ~clr_err;
    unf_d   = unf_q & ~clr_err;
    if (ret) begin
      if (empty) begin
        unf_d = 1'b1;
      end else begin
        pc_d    = top;
        depth_d = depth_q - CW'(1);
      end
    end else if (call) begin
      if (full) begin
        ovf_d = 1'b1;
      end else begin
        push    = 1'b1;
        depth_d = depth_q + CW'(1);
        pc_d    = target;
      end
    end else if (jmp) begin
      pc_d = target;
    end else if (sub) begin
      pc_d = pc_q - offset;
    end else if (add) begin
      pc_d = pc_q + offset;
    end else if (inc) begin
      pc_d = pc_plus1;
    end
  end

  // Update the control state; reset discards the stack and any pending op.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_q    <= RESET_VEC;
      depth_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      depth_q <= depth_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Write the return address into the first free slot. The slot contents need no reset because depth_q tracks which slots are valid.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (reset && push && depth_q == CW'(i)) stack_q[i] <= pc_plus1;
    end
  end

  assign pc        = pc_q;
  assign depth_cnt = depth_q;
  assign stk_empty = empty;
  assign stk_full  = full;
  assign ovf       = ovf_q;
  assign unf       = unf_q;

endmodule

// File: tb/tb_pc_ras.sv
// Directed bench for pc_ras. A reference model pushes the expected state for each step, and the bench pops and compares it one cycle later.
// Latency checked: one cycle per op.
// Backpressure: not applicable. Inputs change on the falling edge and outputs are sampled on the falling edge.
module tb_pc_ras;

  localparam int W = 16;
  localparam int D = 4;

  // Strobe vector layout: {ret, call, jmp, sub, add, inc, clr_err}
  localparam logic [6:0] O_NONE = 7'b0000000;
  localparam logic [6:0] O_CLR  = 7'b0000001;
  localparam logic [6:0] O_INC  = 7'b0000010;
  localparam logic [6:0] O_ADD  = 7'b0000100;
  localparam logic [6:0] O_SUB  = 7'b0001000;
  localparam logic [6:0] O_JMP  = 7'b0010000;
  localparam logic [6:0] O_CALL = 7'b0100000;
  localparam logic [6:0] O_RET  = 7'b1000000;
  localparam logic [6:0] O_ALL  = 7'b1111110;

  typedef struct {
    logic [W-1:0] pc;
    logic [2:0]   depth;
    logic         empty;
    logic         full;
    logic         ovf;
    logic         unf;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset, inc, add, sub, jmp, call, ret, clr_err;
  logic [W-1:0] offset, target, pc;
  logic [2:0]   depth_cnt;
  logic         stk_empty, stk_full, ovf, unf;

  int checks = 0;
  int errors = 0;

  exp_t         sb_q[$];
  logic [W-1:0] m_stk[$];
  logic [W-1:0] m_pc;
  logic         m_ovf, m_unf;

  pc_ras #(.WIDTH(W), .DEPTH(D), .RESET_VEC('0)) dut (
    .clk(clk), .reset(reset), .inc(inc), .add(add), .sub(sub), .jmp(jmp),
    .call(call), .ret(ret), .clr_err(clr_err), .offset(offset), .target(target),
    .pc(pc), .depth_cnt(depth_cnt), .stk_empty(stk_empty), .stk_full(stk_full),
    .ovf(ovf), .unf(unf)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Drive one cycle, update the model and queue its expectation, then compare on the next falling edge.
  task automatic step(input logic rst_n, input logic [6:0] ops, input logic [W-1:0] off,
                      input logic [W-1:0] tgt, input string tag);
    exp_t e;
    logic os, us;
    reset = rst_n;
    {ret, call, jmp, sub, add, inc, clr_err} = ops;
    offset = off;
    target = tgt;
    if (!rst_n) begin
      m_pc = '0;
      m_stk.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      os = 1'b0;
      us = 1'b0;
      if (ops[6]) begin
        if (m_stk.size() == 0) us = 1'b1;
        else m_pc = m_stk.pop_back();
      end else if (ops[5]) begin
        if (m_stk.size() == D) os = 1'b1;
        else begin
          m_stk.push_back(m_pc + 16'd1);
          m_pc = tgt;
        end
      end else if (ops[4]) m_pc = tgt;
      else if (ops[3]) m_pc = m_pc - off;
      else if (ops[2]) m_pc = m_pc + off;
      else if (ops[1]) m_pc = m_pc + 16'd1;
      m_ovf = os | (m_ovf & ~ops[0]);
      m_unf = us | (m_unf & ~ops[0]);
    end
    e.pc    = m_pc;
    e.depth = 3'(m_stk.size());
    e.empty = (m_stk.size() == 0);
    e.full  = (m_stk.size() == D);
    e.ovf   = m_ovf;
    e.unf   = m_unf;
    sb_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s_sb: got empty scoreboard expected entry", tag);
    end else begin
      e = sb_q.pop_front();
      chk({tag, "_pc"},    32'(pc),        32'(e.pc));
      chk({tag, "_depth"}, 32'(depth_cnt), 32'(e.depth));
      chk({tag, "_empty"}, 32'(stk_empty), 32'(e.empty));
      chk({tag, "_full"},  32'(stk_full),  32'(e.full));
      chk({tag, "_ovf"},   32'(ovf),       32'(e.ovf));
      chk({tag, "_unf"},   32'(unf),       32'(e.unf));
    end
  endtask

  initial begin
    reset = 1'b0;
    {ret, call, jmp, sub, add, inc, clr_err} = O_NONE;
    offset = '0;
    target = '0;
    m_pc = '0;
    m_ovf = 1'b0;
    m_unf = 1'b0;
    @(negedge clk);

    // 1: reset, then three increments
    step(1'b0, O_INC, 16'h0, 16'h0, "rst");
    chk("rst_pc_const", 32'(pc), 32'h0);
    chk("rst_empty_const", 32'(stk_empty), 32'h1);
    step(1'b1, O_INC, 16'h0, 16'h0, "inc1");
    step(1'b1, O_INC, 16'h0, 16'h0, "inc2");
    step(1'b1, O_INC, 16'h0, 16'h0, "inc3");
    chk("inc3_pc_const", 32'(pc), 32'h3);

    // 2: modular add, sub, inc and wrap
    step(1'b1, O_JMP, 16'h0, 16'h0010, "jmp10");
    step(1'b1, O_ADD, 16'h0005, 16'h0, "add5");
    chk("add_pc_const", 32'(pc), 32'h0015);
    step(1'b1, O_SUB, 16'h0020, 16'h0, "sub20");
    chk("sub_wrap_const", 32'(pc), 32'hFFF5);
    step(1'b1, O_INC, 16'h0, 16'h0, "incFFF6");
    step(1'b1, O_JMP, 16'h0, 16'hFFFF, "jmpFFFF");
    step(1'b1, O_INC, 16'h0, 16'h0, "inc_wrap");
    chk("inc_wrap_const", 32'(pc), 32'h0);
    step(1'b1, O_NONE, 16'h1234, 16'h5678, "hold");

    // 3: nested call and return
    step(1'b1, O_JMP, 16'h0, 16'h0100, "jmp100");
    step(1'b1, O_CALL, 16'h0, 16'h0200, "call200");
    step(1'b1, O_CALL, 16'h0, 16'h0300, "call300");
    step(1'b1, O_RET, 16'h0, 16'h0, "ret201");
    chk("ret201_const", 32'(pc), 32'h0201);
    step(1'b1, O_RET, 16'h0, 16'h0, "ret101");
    chk("ret101_const", 32'(pc), 32'h0101);

    // 4: fill the stack, overflow it, then drain it and underflow
    step(1'b1, O_JMP, 16'h0, 16'h0000, "jmp0");
    for (int i = 1; i <= 5; i++) step(1'b1, O_CALL, 16'h0, 16'(i * 16), "callN");
    chk("ovf_pc_const", 32'(pc), 32'h0040);
    chk("ovf_flag_const", 32'(ovf), 32'h1);
    chk("ovf_full_const", 32'(stk_full), 32'h1);
    for (int i = 0; i < 5; i++) step(1'b1, O_RET, 16'h0, 16'h0, "retN");
    chk("unf_pc_const", 32'(pc), 32'h0001);
    chk("unf_flag_const", 32'(unf), 32'h1);

    // 5: all strobes at once, set-wins-over-clear, then clear
    step(1'b1, O_CLR, 16'h0, 16'h0, "clr0");
    step(1'b1, O_ALL, 16'h0003, 16'h0AAA, "all");
    chk("all_unf_const", 32'(unf), 32'h1);
    chk("all_pc_const", 32'(pc), 32'h0001);
    step(1'b1, O_RET | O_CLR, 16'h0, 16'h0, "clr_ret");
    chk("setwins_const", 32'(unf), 32'h1);
    step(1'b1, O_CLR, 16'h0, 16'h0, "clr1");
    chk("clr_unf_const", 32'(unf), 32'h0);

    // 6: reset in the middle of a sequence discards the stack
    step(1'b1, O_RET, 16'h0, 16'h0, "pre_unf");
    step(1'b1, O_CALL, 16'h0, 16'h0700, "c1");
    step(1'b1, O_CALL, 16'h0, 16'h0800, "c2");
    step(1'b1, O_CALL, 16'h0, 16'h0900, "c3");
    step(1'b0, O_RET, 16'h0, 16'h0, "rst_ret");
    chk("rst_depth_const", 32'(depth_cnt), 32'h0);
    step(1'b1, O_RET, 16'h0, 16'h0, "post_ret");
    chk("post_unf_const", 32'(unf), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
